// File: rtl/pipeline_skid_buffer_pkg.sv
// rtl/pipeline_skid_buffer_pkg.sv - shared state encodings for datapath buffers
//
// Purpose: state type, state width and small state helpers reused by the
// pipeline buffers of the frame datapath.
package pipeline_skid_buffer_pkg;

  localparam int STATE_WIDTH = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;

  // A buffer can take a new word in every state except FULL.
  function automatic logic state_accepts(input state_t s);
    return (s != FULL);
  endfunction

  // A buffer presents a word downstream in every state except EMPTY.
  function automatic logic state_holds_word(input state_t s);
    return (s != EMPTY);
  endfunction

endpackage

// File: rtl/pipeline_skid_buffer_reg.sv
// rtl/pipeline_skid_buffer_reg.sv - standard register block with enable and clear
//
// Purpose: one register of WIDTH bits, loaded on clock_enable, forced to
// RESET_VALUE by a synchronous clear that takes priority over the enable.
// Ports:
//   clock         rising-edge clock
//   clock_enable  load data_in on this edge
//   clear         synchronous active-high clear
//   data_in       next value
//   data_out      registered value
module pipeline_skid_buffer_reg #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             clock_enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  always_ff @(posedge clock) begin
    if (clear) begin
      data_out <= RESET_VALUE;
    end else if (clock_enable) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/pipeline_skid_buffer.sv
// rtl/pipeline_skid_buffer.sv - two-entry fully registered ready/valid buffer
//
// Purpose: decouples an upstream sender from a downstream receiver with every
// output (data, valid and ready) coming straight from a register, so the
// buffer is a full pipeline cut while still sustaining one word per cycle.
// Ports:
//   clock         sole clock, rising edge
//   clear_n       synchronous active-low reset
//   input_valid   upstream offers input_data
//   input_ready   buffer accepts a word this cycle (registered)
//   input_data    upstream word
//   output_valid  output_data holds a valid word (registered)
//   output_ready  downstream accepts the word
//   output_data   downstream word (registered)
module pipeline_skid_buffer
  import pipeline_skid_buffer_pkg::*;
#(
  parameter int                    WORD_WIDTH  = 0,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [WORD_WIDTH-1:0] input_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] output_data
);

  logic                   w_clear;
  logic                   w_insert;
  logic                   w_remove;

  logic [STATE_WIDTH-1:0] r_state;
  state_t                 w_state;
  state_t                 w_state_next;
  logic                   w_state_en;

  logic [WORD_WIDTH-1:0]  r_main;
  logic [WORD_WIDTH-1:0]  r_skid;
  logic [WORD_WIDTH-1:0]  w_main_next;
  logic                   w_main_en;
  logic                   w_main_from_skid;
  logic                   w_skid_en;

  logic                   r_input_ready;
  logic                   r_output_valid;
  logic                   w_ready_next;
  logic                   w_valid_next;
  logic                   w_ready_en;
  logic                   w_valid_en;

  assign w_clear  = ~clear_n;
  assign w_insert = input_valid & r_input_ready;
  assign w_remove = r_output_valid & output_ready;
  assign w_state  = state_t'(r_state);

  always_comb begin
    w_state_next     = w_state;
    w_main_en        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_en        = 1'b0;
    case (w_state)
      EMPTY: begin
        if (w_insert) begin
          w_state_next = BUSY;
          w_main_en    = 1'b1;
        end
      end
      BUSY: begin
        if (w_insert && !w_remove) begin
          // Downstream stalled: park the new word behind the one on the output.
          w_state_next = FULL;
          w_skid_en    = 1'b1;
        end else if (w_insert && w_remove) begin
          w_main_en = 1'b1;
        end else if (!w_insert && w_remove) begin
          // Main register keeps the stale word; output_valid marks it dead.
          w_state_next = EMPTY;
        end
      end
      FULL: begin
        if (w_remove) begin
          w_state_next     = BUSY;
          w_main_en        = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_next = EMPTY;
      end
    endcase
  end

  assign w_main_next  = w_main_from_skid ? r_skid : input_data;
  assign w_state_en   = (w_state_next != w_state);

  // The handshake registers track the next state; comparing against their own
  // value also lets input_ready rise on the first edge after reset release,
  // when the state is already EMPTY but input_ready was cleared.
  assign w_ready_next = state_accepts(w_state_next);
  assign w_valid_next = state_holds_word(w_state_next);
  assign w_ready_en   = (w_ready_next != r_input_ready);
  assign w_valid_en   = (w_valid_next != r_output_valid);

  pipeline_skid_buffer_reg #(
    .WIDTH       (STATE_WIDTH),
    .RESET_VALUE (STATE_WIDTH'(EMPTY))
  ) u_state_reg (
    .clock        (clock),
    .clock_enable (w_state_en),
    .clear        (w_clear),
    .data_in      (w_state_next),
    .data_out     (r_state)
  );

  pipeline_skid_buffer_reg #(
    .WIDTH       (WORD_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_main_reg (
    .clock        (clock),
    .clock_enable (w_main_en),
    .clear        (w_clear),
    .data_in      (w_main_next),
    .data_out     (r_main)
  );

  pipeline_skid_buffer_reg #(
    .WIDTH       (WORD_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_skid_reg (
    .clock        (clock),
    .clock_enable (w_skid_en),
    .clear        (w_clear),
    .data_in      (input_data),
    .data_out     (r_skid)
  );

  pipeline_skid_buffer_reg #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) u_input_ready_reg (
    .clock        (clock),
    .clock_enable (w_ready_en),
    .clear        (w_clear),
    .data_in      (w_ready_next),
    .data_out     (r_input_ready)
  );

  pipeline_skid_buffer_reg #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) u_output_valid_reg (
    .clock        (clock),
    .clock_enable (w_valid_en),
    .clear        (w_clear),
    .data_in      (w_valid_next),
    .data_out     (r_output_valid)
  );

  assign input_ready  = r_input_ready;
  assign output_valid = r_output_valid;
  assign output_data  = r_main;

endmodule

// File: tb/tb_pipeline_skid_buffer.sv
// tb/tb_pipeline_skid_buffer.sv - self-checking bench for pipeline_skid_buffer
module tb_pipeline_skid_buffer;

  logic       clock;
  logic       clear_n;
  logic       input_valid;
  logic       input_ready;
  logic [7:0] input_data;
  logic       output_valid;
  logic       output_ready;
  logic [7:0] output_data;

  int n_cmp;
  int n_fail;

  pipeline_skid_buffer #(
    .WORD_WIDTH  (8),
    .RESET_VALUE (8'h00)
  ) dut (
    .clock        (clock),
    .clear_n      (clear_n),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       clear_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       exp_ready;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic cn, input logic v, input logic [7:0] d, input logic r);
    clear_n      = cn;
    input_valid  = v;
    input_data   = d;
    output_ready = r;
  endtask

  byte unsigned q[$];
  byte unsigned next_word;
  logic         m_ins;
  logic         m_rem;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    //          clear_n valid data   ready  exp_ir exp_ov exp_data
    vecs[0]  = '{1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 8'h00};  // reset
    vecs[1]  = '{1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 8'h00};  // reset
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};  // ready rises
    vecs[3]  = '{1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA1};  // EMPTY->BUSY
    vecs[4]  = '{1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA1};  // BUSY->FULL (skid)
    vecs[5]  = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA1};  // A3 held off
    vecs[6]  = '{1'b1, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA2};  // FULL->BUSY
    vecs[7]  = '{1'b1, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA3};  // flow, A3 in
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA3};  // BUSY->EMPTY, stale
    vecs[9]  = '{1'b1, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h44};  // 0x44 in
    vecs[10] = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h55};  // insert 55 remove 44
    vecs[11] = '{1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 8'h55};  // FULL
    vecs[12] = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00};  // reset in FULL
    vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};  // no old words
    vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].clear_n, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d input_ready", i), 32'(input_ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d output_valid", i), 32'(output_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d output_data", i), 32'(output_data), 32'(vecs[i].exp_data));
    end

    // Back-to-back flow of 0x01..0x10 with output_ready held high.
    for (int w = 1; w <= 16; w++) begin
      drive(1'b1, 1'b1, 8'(w), 1'b1);
      @(posedge clock);
      #1;
      check($sformatf("flow%0d output_valid", w), 32'(output_valid), 32'd1);
      check($sformatf("flow%0d output_data", w), 32'(output_data), 32'(w));
      check($sformatf("flow%0d input_ready", w), 32'(input_ready), 32'd1);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    @(posedge clock);
    #1;
    check("flow drain output_valid", 32'(output_valid), 32'd0);

    // Random valid/ready against a two-slot FIFO model.
    q.delete();
    next_word = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), next_word, ($urandom_range(0, 3) != 0));
      m_ins = input_valid && (q.size() < 2);
      m_rem = output_ready && (q.size() > 0);
      @(posedge clock);
      if (m_rem) void'(q.pop_front());
      if (m_ins) begin
        q.push_back(next_word);
        next_word++;
      end
      #1;
      check("rand input_ready", 32'(input_ready), 32'(q.size() < 2));
      check("rand output_valid", 32'(output_valid), 32'(q.size() > 0));
      if (q.size() > 0) check("rand output_data", 32'(output_data), 32'(q[0]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
